// File: rtl/drum_audio_pkg.sv
// Shared types and register map for the drum solver audio transmitter.
package drum_audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SPACE,
        CHECK,
        WR_L,
        WR_R
    } state_t;

    localparam logic [31:0] FIFOSPACE_OFF = 32'd4;
    localparam logic [31:0] LEFT_OFF      = 32'd8;
    localparam logic [31:0] RIGHT_OFF     = 32'd12;

    // FIFOSPACE fields: write space left (WSLC) and right (WSRC)
    localparam int unsigned WSLC_MSB = 31;
    localparam int unsigned WSLC_LSB = 24;
    localparam int unsigned WSRC_MSB = 23;
    localparam int unsigned WSRC_LSB = 16;

endpackage

// File: rtl/drum_audio_tx_fifo.sv
// Small registered sample FIFO; extra pointer bit separates full from empty.
module sample_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        dout    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/drum_audio_tx.sv
// Drum solver sample sink: FIFO, scaling, Avalon-MM writes to the audio core.
// Define AUDIO_SAT_EN to saturate the scaled word instead of wrapping.
module drum_audio_tx
    import drum_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 18,
    parameter int unsigned AUD_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAIN_SHL   = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3040
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic [31:0]         avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [AUD_W-1:0]    avm_writedata,
    input  logic [AUD_W-1:0]    avm_readdata,
    input  logic                avm_waitrequest,
    output logic [15:0]         underrun_cnt,
    output logic                busy
);

    localparam logic [31:0] SPACE_ADDR = BASE_ADDR + FIFOSPACE_OFF;
    localparam logic [31:0] LEFT_ADDR  = BASE_ADDR + LEFT_OFF;
    localparam logic [31:0] RIGHT_ADDR = BASE_ADDR + RIGHT_OFF;

    state_t               state_q, state_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;
    logic [31:0]          addr_q, addr_d;
    logic [AUD_W-1:0]     wdata_q, wdata_d;
    logic [7:0]           wslc_q, wslc_d;
    logic [7:0]           wsrc_q, wsrc_d;
    logic [15:0]          underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]  head;
    logic [AUD_W-1:0]     word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 unused_rd;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50),
        .rst_n (reset),
        .push  (sample_valid),
        .din   (sample_in),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AUDIO_SAT_EN
    localparam int unsigned WIDE_W = AUD_W + GAIN_SHL;
    logic [WIDE_W-1:0] wide;
    logic [GAIN_SHL:0] hi;

    // In range only when every bit above the result sign matches it
    always_comb begin
        wide = WIDE_W'($signed(head)) << GAIN_SHL;
        hi   = wide[WIDE_W-1:AUD_W-1];
        if ((hi == '0) || (hi == '1)) begin
            word = wide[AUD_W-1:0];
        end else if (head[SAMPLE_W-1]) begin
            word = {1'b1, {(AUD_W-1){1'b0}}};
        end else begin
            word = {1'b0, {(AUD_W-1){1'b1}}};
        end
    end
`else
    logic [AUD_W-1:0] ext;

    always_comb begin
        ext  = AUD_W'($signed(head));
        word = ext << GAIN_SHL;
    end
`endif

    always_comb begin
        sample_ready  = !fifo_full;
        avm_address   = addr_q;
        avm_read      = read_q;
        avm_write     = write_q;
        avm_writedata = wdata_q;
        underrun_cnt  = underrun_q;
        busy          = busy_q;
        unused_rd     = ^avm_readdata[WSRC_LSB-1:0];
    end

    always_comb begin
        state_d    = state_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wslc_d     = wslc_q;
        wsrc_d     = wsrc_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = RD_SPACE;
                    read_d  = 1'b1;
                    addr_d  = SPACE_ADDR;
                end
            end
            RD_SPACE: begin
                if (avm_waitrequest) begin
                    read_d = 1'b1;
                end else begin
                    wslc_d  = avm_readdata[WSLC_MSB:WSLC_LSB];
                    wsrc_d  = avm_readdata[WSRC_MSB:WSRC_LSB];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((wslc_q != '0) && (wsrc_q != '0)) begin
                    if (!fifo_empty) begin
                        state_d = WR_L;
                        write_d = 1'b1;
                        addr_d  = LEFT_ADDR;
                        wdata_d = word;
                    end else if (underrun_q != '1) begin
                        underrun_d = underrun_q + 16'd1;
                    end
                end
            end
            WR_L: begin
                write_d = 1'b1;
                if (!avm_waitrequest) begin
                    state_d = WR_R;
                    addr_d  = RIGHT_ADDR;
                end
            end
            WR_R: begin
                if (avm_waitrequest) begin
                    write_d = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wslc_q     <= '0;
            wsrc_q     <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wslc_q     <= wslc_d;
            wsrc_q     <= wsrc_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
